// File: rtl/fma16_operand_classifier.sv
// fp16 FMA front end: field split, operand classes and
// special-case flags, behind a registered skid-buffered output.
module fma16_operand_classifier #(
  parameter int          CNT_W = 16,
  parameter logic [15:0] QNAN  = 16'h7E00
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      x,
  input  logic [15:0]      y,
  input  logic [15:0]      z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_x,
  output logic             sign_y,
  output logic             sign_z,
  output logic [4:0]       exponent_x,
  output logic [4:0]       exponent_y,
  output logic [4:0]       exponent_z,
  output logic [9:0]       fraction_x,
  output logic [9:0]       fraction_y,
  output logic [9:0]       fraction_z,
  output logic [4:0]       class_x,
  output logic [4:0]       class_y,
  output logic [4:0]       class_z,
  output logic             sign_product,
  output logic             special_valid,
  output logic [15:0]      special_result,
  output logic             invalid,
  output logic [CNT_W-1:0] invalid_count
);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [4:0]  cx;
    logic [4:0]  cy;
    logic [4:0]  cz;
    logic        sv;
    logic [15:0] sr;
    logic        inv;
  } cls_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // class bits: {snan,qnan,inf,sub,zero}
  function automatic logic [4:0] classify(
    input logic [15:0] v
  );
    logic [4:0] e;
    logic [9:0] f;
    logic [4:0] c;
    e = v[14:10];
    f = v[9:0];
    c = 5'b00000;
    unique case (1'b1)
      (e == 5'd0) && (f == 10'd0):
        c = 5'b00001;
      (e == 5'd0) && (f != 10'd0):
        c = 5'b00010;
      (e == 5'd31) && (f == 10'd0):
        c = 5'b00100;
      (e == 5'd31) && f[9]:
        c = 5'b01000;
      (e == 5'd31) && !f[9] && (f != 10'd0):
        c = 5'b10000;
      default:
        c = 5'b00000;
    endcase
    return c;
  endfunction

  cls_t       nxt;
  cls_t       out_q;
  cls_t       skid_q;
  logic       skid_full;
  logic       in_xfer;
  logic       any_nan;
  logic       any_snan;
  logic       zero_inf;
  logic       prod_inf;
  logic       sp;

  assign in_ready = ~skid_full;
  assign in_xfer  = in_valid & in_ready;

  // classify the incoming triple and resolve special outcomes
  always_comb begin
    nxt      = '0;
    nxt.x    = x;
    nxt.y    = y;
    nxt.z    = z;
    nxt.cx   = classify(x);
    nxt.cy   = classify(y);
    nxt.cz   = classify(z);
    sp       = x[15] ^ y[15];
    any_nan  = |{nxt.cx[4:3], nxt.cy[4:3], nxt.cz[4:3]};
    any_snan = nxt.cx[4] | nxt.cy[4] | nxt.cz[4];
    zero_inf = (nxt.cx[0] & nxt.cy[2])
             | (nxt.cx[2] & nxt.cy[0]);
    prod_inf = nxt.cx[2] | nxt.cy[2];
    if (any_nan) begin
      nxt.sv = 1'b1;
      nxt.sr = QNAN;
    end else if (zero_inf) begin
      nxt.sv  = 1'b1;
      nxt.sr  = QNAN;
      nxt.inv = 1'b1;
    end else if (prod_inf && nxt.cz[2]
                 && (sp != z[15])) begin
      nxt.sv  = 1'b1;
      nxt.sr  = QNAN;
      nxt.inv = 1'b1;
    end else if (prod_inf) begin
      nxt.sv = 1'b1;
      nxt.sr = {sp, 15'h7C00};
    end else if (nxt.cz[2]) begin
      nxt.sv = 1'b1;
      nxt.sr = {z[15], 15'h7C00};
    end
    nxt.inv = nxt.inv | any_snan;
  end

  // output register with one-entry skid buffer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (out_valid && !out_ready) begin
      if (in_xfer) begin
        skid_q    <= nxt;
        skid_full <= 1'b1;
      end
    end else if (skid_full) begin
      out_q     <= skid_q;
      out_valid <= 1'b1;
      skid_full <= 1'b0;
    end else if (in_xfer) begin
      out_q     <= nxt;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  // saturating count of accepted invalid triples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      invalid_count <= '0;
    end else if (in_xfer && nxt.inv
                 && (invalid_count != CNT_MAX)) begin
      invalid_count <= invalid_count + 1'b1;
    end
  end

  assign sign_x         = out_q.x[15];
  assign sign_y         = out_q.y[15];
  assign sign_z         = out_q.z[15];
  assign exponent_x     = out_q.x[14:10];
  assign exponent_y     = out_q.y[14:10];
  assign exponent_z     = out_q.z[14:10];
  assign fraction_x     = out_q.x[9:0];
  assign fraction_y     = out_q.y[9:0];
  assign fraction_z     = out_q.z[9:0];
  assign class_x        = out_q.cx;
  assign class_y        = out_q.cy;
  assign class_z        = out_q.cz;
  assign sign_product   = out_q.x[15] ^ out_q.y[15];
  assign special_valid  = out_q.sv;
  assign special_result = out_q.sr;
  assign invalid        = out_q.inv;

endmodule

// File: tb/tb_fma16_operand_classifier.sv
// Scoreboard bench for the fp16 operand classifier:
// directed vectors, queue of expected results, monitor.
module tb_fma16_operand_classifier;

  localparam int CNT_W = 2;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [4:0]  cx;
    logic [4:0]  cy;
    logic [4:0]  cz;
    logic        sv;
    logic [15:0] sr;
    logic        inv;
  } vec_t;

  logic             clk = 0;
  logic             reset_n = 0;
  logic             in_valid = 0;
  logic             in_ready;
  logic [15:0]      x = 0;
  logic [15:0]      y = 0;
  logic [15:0]      z = 0;
  logic             out_valid;
  logic             out_ready = 1;
  logic             sign_x, sign_y, sign_z;
  logic [4:0]       exponent_x, exponent_y, exponent_z;
  logic [9:0]       fraction_x, fraction_y, fraction_z;
  logic [4:0]       class_x, class_y, class_z;
  logic             sign_product;
  logic             special_valid;
  logic [15:0]      special_result;
  logic             invalid;
  logic [CNT_W-1:0] invalid_count;

  fma16_operand_classifier #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_x(sign_x), .sign_y(sign_y), .sign_z(sign_z),
    .exponent_x(exponent_x), .exponent_y(exponent_y),
    .exponent_z(exponent_z),
    .fraction_x(fraction_x), .fraction_y(fraction_y),
    .fraction_z(fraction_z),
    .class_x(class_x), .class_y(class_y),
    .class_z(class_z),
    .sign_product(sign_product),
    .special_valid(special_valid),
    .special_result(special_result),
    .invalid(invalid),
    .invalid_count(invalid_count)
  );

  always #5 clk = ~clk;

  int   nchk = 0;
  int   errs = 0;
  int   exp_cnt = 0;
  vec_t sb[$];
  vec_t tab[12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h",
               name, act, req);
    end
  endtask

  // monitor: compare each presented transfer with the queue head
  always @(negedge clk) begin
    vec_t act;
    vec_t e;
    if (reset_n && out_valid && out_ready) begin
      act = {{sign_x, exponent_x, fraction_x},
             {sign_y, exponent_y, fraction_y},
             {sign_z, exponent_z, fraction_z},
             class_x, class_y, class_z,
             special_valid, special_result, invalid};
      nchk++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected_output: got %h", act);
      end else begin
        e = sb.pop_front();
        if (act !== e ||
            sign_product !== (e.x[15] ^ e.y[15])) begin
          errs++;
          $display("FAIL out_%h_%h_%h: got %h sp=%b expected %h",
                   e.x, e.y, e.z, act, sign_product, e);
        end
      end
    end
  end

  task automatic send(input vec_t v, input bit lat_chk);
    int n;
    bit ok;
    x = v.x;
    y = v.y;
    z = v.z;
    in_valid = 1;
    n = 0;
    ok = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      if (ok) sb.push_back(v);
      n++;
      @(posedge clk);
    end while (!ok && n < 20);
    #1;
    in_valid = 0;
    if (!ok) begin
      nchk++;
      errs++;
      $display("FAIL send_timeout: got busy expected ready");
    end else begin
      if (v.inv && exp_cnt != 3) exp_cnt++;
      chk("invalid_count", 32'(invalid_count), 32'(exp_cnt));
      if (lat_chk) chk("latency_out_valid", 32'(out_valid), 32'd1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    //           x        y        z        cx       cy       cz      sv  sr      inv
    tab[0]  = '{16'h3C00,16'h4000,16'h3C00,5'b00000,5'b00000,5'b00000,1'b0,16'h0000,1'b0};
    tab[1]  = '{16'h0000,16'h7C00,16'h3C00,5'b00001,5'b00100,5'b00000,1'b1,16'h7E00,1'b1};
    tab[2]  = '{16'h7C00,16'h3C00,16'hFC00,5'b00100,5'b00000,5'b00100,1'b1,16'h7E00,1'b1};
    tab[3]  = '{16'h7C00,16'hBC00,16'h3C00,5'b00100,5'b00000,5'b00000,1'b1,16'hFC00,1'b0};
    tab[4]  = '{16'h7D00,16'h3C00,16'h3C00,5'b10000,5'b00000,5'b00000,1'b1,16'h7E00,1'b1};
    tab[5]  = '{16'h7E00,16'h3C00,16'h3C00,5'b01000,5'b00000,5'b00000,1'b1,16'h7E00,1'b0};
    tab[6]  = '{16'h0001,16'h8000,16'h4000,5'b00010,5'b00001,5'b00000,1'b0,16'h0000,1'b0};
    tab[7]  = '{16'h3C00,16'h3C00,16'hFC00,5'b00000,5'b00000,5'b00100,1'b1,16'hFC00,1'b0};
    tab[8]  = '{16'h7C00,16'h7C00,16'h7C00,5'b00100,5'b00100,5'b00100,1'b1,16'h7C00,1'b0};
    tab[9]  = '{16'h3C00,16'h7D00,16'h3C00,5'b00000,5'b10000,5'b00000,1'b1,16'h7E00,1'b1};
    tab[10] = '{16'h3C00,16'h3C00,16'h7C01,5'b00000,5'b00000,5'b10000,1'b1,16'h7E00,1'b1};
    tab[11] = '{16'hFC00,16'hFC00,16'hFC00,5'b00100,5'b00100,5'b00100,1'b1,16'h7E00,1'b1};

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(invalid_count), 32'd0);
    chk("rst_data", {16'(special_result), 11'd0, class_x},
        32'd0);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;

    // streaming directed vectors, counter saturates at 3
    foreach (tab[i]) send(tab[i], 1'b1);
    drain();

    // five more invalid triples: counter stays at 3
    for (int i = 0; i < 5; i++) send(tab[1], 1'b1);
    drain();

    // stall: first on output, second in skid
    out_ready = 0;
    send(tab[0], 1'b0);
    send(tab[6], 1'b0);
    chk("skid_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_x", 32'({sign_x, exponent_x, fraction_x}),
          32'(tab[0].x));
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("second_beat_valid", 32'(out_valid), 32'd1);
    drain();
    chk("post_drain_in_ready", 32'(in_ready), 32'd1);

    // reset in the middle of a stall
    out_ready = 0;
    send(tab[2], 1'b0);
    send(tab[4], 1'b0);
    #3;
    reset_n = 0;
    #1;
    sb.delete();
    exp_cnt = 0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(invalid_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_data", 32'({sign_x, exponent_x, fraction_x}),
        32'd0);
    @(negedge clk);
    reset_n = 1;
    out_ready = 1;
    @(posedge clk);
    #1;
    send(tab[1], 1'b1);
    send(tab[8], 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             nchk, errs);
    $finish;
  end

endmodule
